// File: rtl/core_pkg.sv
// Shared core definitions: PC sequencer state encoding and fetch constants.
package core_pkg;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    ERR
  } pcseq_state_e;

  localparam int unsigned PC_INC           = 4;
  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch sequencing: sequential advance, EX redirects,
// load-use stalls, redirect hold across an outstanding fetch, misalign trap.
module pc_sequencer
  import core_pkg::*;
#(
  parameter int unsigned PC_W     = 9,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             stall_req,
  input  logic             imem_ready,
  output logic [PC_W-1:0]  pc,
  output logic             imem_req,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  pcseq_state_e    state;
  logic [PC_W-1:0] pend_target;
  logic [PC_W-1:0] br_pc;
  logic            misalign;
  logic            cnt_inc;
  logic            unused_target;

  // Target bits above the PC width are dropped silently.
  assign br_pc         = br_target[PC_W-1:0];
  assign unused_target = ^br_target;
  assign misalign      = br_taken && (br_target[1:0] != 2'b00);

  always_comb begin
    imem_req    = 1'b1;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    cnt_inc     = 1'b0;
    unique case (state)
      RUN: begin
        if (br_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          cnt_inc     = !misalign && imem_ready;
        end else if (stall_req) begin
          id_ex_flush = 1'b1;
        end else begin
          if_id_en = imem_ready;
        end
      end
      PEND: begin
        if_id_flush = 1'b1;
        cnt_inc     = imem_ready;
      end
      default: begin
        imem_req    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc           <= PC_W'(RESET_PC);
      pend_target  <= '0;
      misalign_err <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (br_taken) begin
            if (misalign) begin
              state        <= ERR;
              misalign_err <= 1'b1;
            end else if (imem_ready) begin
              pc <= br_pc;
            end else begin
              pend_target <= br_pc;
              state       <= PEND;
            end
          end else if (!stall_req && imem_ready) begin
            pc <= pc + PC_W'(PC_INC);
          end
        end
        PEND: begin
          if (imem_ready) begin
            pc    <= pend_target;
            state <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .count (redirect_cnt)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;

  localparam int PC_W  = 9;
  localparam int CNT_W = 4;
  localparam int RST   = 0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             br_taken;
  logic [31:0]      br_target;
  logic             stall_req;
  logic             imem_ready;
  logic [PC_W-1:0]  pc;
  logic             imem_req;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             misalign_err;
  logic [CNT_W-1:0] redirect_cnt;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(RST), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .stall_req    (stall_req),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .imem_req     (imem_req),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .misalign_err (misalign_err),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model state: plain integers, a "redirect waiting" flag and a "trapped" flag.
  int m_pc = RST, m_tgt = 0, m_cnt = 0;
  bit m_pend = 0, m_err = 0;

  always @(negedge clk) begin
    int e_req, e_ifl, e_idx, e_en;
    bit en_care;
    if (!rst_n) begin
      m_pc = RST; m_tgt = 0; m_cnt = 0; m_pend = 0; m_err = 0;
    end
    en_care = 0; e_en = 0;
    if (m_err) begin
      e_req = 0; e_ifl = 1; e_idx = 1;
    end else if (m_pend) begin
      e_req = 1; e_ifl = 1; e_idx = id_ex_flush;
    end else if (br_taken) begin
      e_req = 1; e_ifl = 1; e_idx = 1;
    end else if (stall_req) begin
      e_req = 1; e_ifl = 0; e_idx = 1; en_care = 1; e_en = 0;
    end else begin
      e_req = 1; e_ifl = 0; e_idx = 0; en_care = 1; e_en = imem_ready;
    end
    chk("m_pc", pc, m_pc);
    chk("m_cnt", redirect_cnt, m_cnt);
    chk("m_err", misalign_err, m_err);
    chk("m_req", imem_req, e_req);
    chk("m_ifl", if_id_flush, e_ifl);
    if (!m_pend) chk("m_idx", id_ex_flush, e_idx);
    if (en_care) chk("m_en", if_id_en, e_en);
    if (rst_n && !m_err) begin
      if (m_pend) begin
        if (imem_ready) begin
          m_pc = m_tgt; m_pend = 0;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
      end else if (br_taken) begin
        if (br_target % 4 != 0) m_err = 1;
        else if (imem_ready) begin
          m_pc = br_target % (1 << PC_W);
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else begin
          m_tgt = br_target % (1 << PC_W); m_pend = 1;
        end
      end else if (!stall_req && imem_ready) begin
        m_pc = (m_pc + 4) % (1 << PC_W);
      end
    end
  end

  task automatic set_in(input bit br, input logic [31:0] tgt, input bit st, input bit rdy);
    br_taken = br; br_target = tgt; stall_req = st; imem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int errc;
    logic [31:0] t;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_pc", pc, 0);
    chk("rst_cnt", redirect_cnt, 0);
    chk("rst_err", misalign_err, 0);
    chk("rst_req", imem_req, 1);

    // sequential advance
    set_in(0, 0, 0, 1); #1;
    chk("seq_ifl", if_id_flush, 0);
    chk("seq_idx", id_ex_flush, 0);
    chk("seq_en", if_id_en, 1);
    tick(); chk("seq_pc4", pc, 4);
    tick(); chk("seq_pc8", pc, 8);
    tick(); chk("seq_pc12", pc, 12);

    // immediate redirect
    set_in(1, 32'h40, 0, 1); #1;
    chk("br_ifl", if_id_flush, 1);
    chk("br_idx", id_ex_flush, 1);
    tick(); chk("br_pc", pc, 'h40); chk("br_cnt", redirect_cnt, 1);

    // redirect held across an outstanding fetch; br_taken ignored in PEND
    set_in(1, 32'h80, 0, 0); #1;
    chk("pend0_ifl", if_id_flush, 1);
    tick(); chk("pend1_pc", pc, 'h40);
    set_in(1, 32'h100, 0, 0); #1 chk("pend1_ifl", if_id_flush, 1);
    tick(); chk("pend2_pc", pc, 'h40);
    set_in(0, 0, 1, 0); #1 chk("pend2_ifl", if_id_flush, 1);
    chk("pend2_req", imem_req, 1);
    tick(); chk("pend3_pc", pc, 'h40);
    set_in(0, 0, 0, 1); #1 chk("pend3_ifl", if_id_flush, 1);
    tick(); chk("pend_pc", pc, 'h80); chk("pend_cnt", redirect_cnt, 2);

    // load-use stall
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 1, 1); #1;
      chk("stall_en", if_id_en, 0);
      chk("stall_idx", id_ex_flush, 1);
      tick(); chk("stall_pc", pc, 'h80);
    end
    set_in(0, 0, 0, 1); tick(); chk("unstall_pc", pc, 'h84);

    // redirect beats stall
    set_in(1, 32'h20, 1, 1); tick();
    chk("brst_pc", pc, 'h20); chk("brst_cnt", redirect_cnt, 3);

    // upper target bits discarded, then pc+4 wraps
    set_in(1, 32'hFFFF_FFFC, 0, 1); tick();
    chk("wide_pc", pc, 'h1FC); chk("wide_err", misalign_err, 0);
    set_in(0, 0, 0, 1); tick(); chk("wrap_pc", pc, 0);
    tick(); chk("wrap_pc4", pc, 4);

    // misaligned target traps until reset
    set_in(1, 32'h42, 0, 1); #1;
    chk("mis_ifl", if_id_flush, 1);
    chk("mis_idx", id_ex_flush, 1);
    tick(); chk("mis_err", misalign_err, 1); chk("mis_req", imem_req, 0);
    chk("mis_pc", pc, 4);
    set_in(1, 32'h80, 0, 1); tick(); tick();
    chk("mis_hold_pc", pc, 4); chk("mis_hold_cnt", redirect_cnt, 4);
    #2 rst_n = 1'b0; #1;
    chk("arst_pc", pc, RST); chk("arst_err", misalign_err, 0);
    chk("arst_cnt", redirect_cnt, 0); chk("arst_req", imem_req, 1);
    tick(); rst_n = 1'b1;

    // randomized traffic; reset escapes ERR and occasionally hits other states
    errc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_err) errc++;
      if (errc > 4 || $urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; errc = 0;
      end else begin
        rst_n = 1'b1;
      end
      t = $urandom;
      if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
      set_in($urandom_range(0, 99) < 15, t, $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 70);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
